// File: rtl/mole_sequencer.sv
// Whack-a-mole round controller: picks a pseudo-random lit position per round,
// judges hits against it and keeps saturating score/miss counts for one game.
module mole_sequencer #(
    parameter int         ON_CYCLES  = 25_000_000,
    parameter int         OFF_CYCLES = 12_500_000,
    parameter int         NUM_ROUNDS = 20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hit_valid,
    input  logic [3:0] hit_index,
    output logic [3:0] light_index,
    output logic       light_on,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic       round_done,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    localparam logic [31:0] ON_LOAD  = 32'(ON_CYCLES - 1);
    localparam logic [31:0] OFF_LOAD = 32'(OFF_CYCLES - 1);
    localparam logic [7:0]  LAST_RND = 8'(NUM_ROUNDS);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [7:0]  lfsr;
    logic [7:0]  round_cnt, round_n;
    logic [7:0]  score_n, misses_n;
    logic [3:0]  idx_n;
    logic        round_done_n;
    logic        end_round;
    logic        hit_match;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Fold 0..15 onto 0..8, then step past the previous position so a mole never repeats.
    function automatic logic [3:0] pick_pos(input logic [3:0] raw, input logic [3:0] prev);
        logic [3:0] p;
        p = (raw >= 4'd9) ? raw - 4'd9 : raw;
        if (p == prev)
            p = (p == 4'd8) ? 4'd0 : p + 4'd1;
        return p;
    endfunction

    assign hit_match = hit_valid && (hit_index == light_index);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = light_index;
        score_n      = score;
        misses_n     = misses;
        round_n      = round_cnt;
        round_done_n = 1'b0;
        end_round    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = GAP;
                    cnt_n    = OFF_LOAD;
                    score_n  = 8'd0;
                    misses_n = 8'd0;
                    round_n  = 8'd0;
                end
            end
            GAP: begin
                if (cnt == 32'd0) begin
                    state_n = SHOW;
                    cnt_n   = ON_LOAD;
                    idx_n   = pick_pos(lfsr[3:0], light_index);
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            SHOW: begin
                // A matching hit wins over the timeout on the final lit cycle.
                if (hit_match) begin
                    score_n   = sat_inc(score);
                    end_round = 1'b1;
                end else if (cnt == 32'd0) begin
                    misses_n  = sat_inc(misses);
                    end_round = 1'b1;
                end else begin
                    cnt_n = cnt - 32'd1;
                end
                if (end_round) begin
                    round_done_n = 1'b1;
                    round_n      = round_cnt + 8'd1;
                    if (round_n == LAST_RND) begin
                        state_n = DONE;
                    end else begin
                        state_n = GAP;
                        cnt_n   = OFF_LOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            lfsr        <= LFSR_SEED;
            round_cnt   <= 8'd0;
            light_index <= 4'd0;
            light_on    <= 1'b0;
            score       <= 8'd0;
            misses      <= 8'd0;
            round_done  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            round_cnt   <= round_n;
            light_index <= idx_n;
            light_on    <= (state_n == SHOW);
            score       <= score_n;
            misses      <= misses_n;
            round_done  <= round_done_n;
            game_over   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer with ON=4, OFF=2, 3 rounds; a background
// monitor checks every newly lit position against an LFSR reference.
module tb_mole_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       hit_valid = 1'b0;
    logic [3:0] hit_index = 4'd0;
    logic [3:0] light_index;
    logic       light_on;
    logic [7:0] score;
    logic [7:0] misses;
    logic       round_done;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    mole_sequencer #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .NUM_ROUNDS(3),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .hit_valid  (hit_valid),
        .hit_index  (hit_index),
        .light_index(light_index),
        .light_on   (light_on),
        .score      (score),
        .misses     (misses),
        .round_done (round_done),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_pick(input logic [3:0] raw, input logic [3:0] prev);
        logic [3:0] r;
        r = (raw > 4'd8) ? raw - 4'd9 : raw;
        if (r == prev) r = (r == 4'd8) ? 4'd0 : r + 4'd1;
        return r;
    endfunction

    // Reference LFSR, stepped on the same edges as the DUT.
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_prev = 8'hA5;
    logic       rst_seen = 1'b1;
    always @(posedge clk) begin
        m_prev   = m_lfsr;
        rst_seen = reset;
        if (reset) m_lfsr = 8'hA5;
        else       m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    logic       prev_on = 1'b0;
    logic [3:0] prev_idx = 4'd0;
    always @(negedge clk) begin
        if (light_on && !prev_on) begin
            chk("pick", 32'(light_index), 32'(ref_pick(m_prev[3:0], prev_idx)));
            chk("pick_range", 32'(light_index <= 4'd8), 32'd1);
            chk("pick_norepeat", 32'(light_index != prev_idx), 32'd1);
        end else if (!rst_seen && light_index != prev_idx) begin
            chk("idx_stable", 32'(light_index), 32'(prev_idx));
        end
        prev_on  = light_on;
        prev_idx = light_index;
    end

    task automatic wait_light();
        for (int i = 0; i < 20; i++) begin
            if (light_on) break;
            @(negedge clk);
        end
        chk("wait_light", 32'(light_on), 32'd1);
    endtask

    task automatic wait_round_done();
        for (int i = 0; i < 20; i++) begin
            if (round_done) break;
            @(negedge clk);
        end
        chk("wait_round_done", 32'(round_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k;
        int         on_len;
        int         n;
        logic       held;

        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        chk("rst_light_on", 32'(light_on), 32'd0);
        chk("rst_light_index", 32'(light_index), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_misses", 32'(misses), 32'd0);
        chk("rst_round_done", 32'(round_done), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'hA5);
        reset = 1'b0;
        hit_valid = 1'b1;
        hit_index = 4'd0;
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
        chk("idle_hit_score", 32'(score), 32'd0);
        chk("idle_hit_light", 32'(light_on), 32'd0);
        chk("idle_hit_done", 32'(round_done), 32'd0);

        // Round 1: start, then a matching hit on the second lit cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gap1_light", 32'(light_on), 32'd0);
        chk("gap1_game_over", 32'(game_over), 32'd0);
        @(negedge clk);
        chk("gap2_light", 32'(light_on), 32'd0);
        @(negedge clk);
        chk("show_rise_c3", 32'(light_on), 32'd1);
        k = light_index;
        @(negedge clk);
        hit_valid = 1'b1;
        hit_index = k;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("hit_score", 32'(score), 32'd1);
        chk("hit_round_done", 32'(round_done), 32'd1);
        chk("hit_light_off", 32'(light_on), 32'd0);
        chk("hit_misses", 32'(misses), 32'd0);
        @(negedge clk);
        chk("hit_done_pulse", 32'(round_done), 32'd0);

        // Round 2: timeout
        wait_light();
        on_len = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!light_on) break;
            on_len++;
        end
        chk("timeout_len", 32'(on_len), 32'd4);
        chk("timeout_misses", 32'(misses), 32'd1);
        chk("timeout_round_done", 32'(round_done), 32'd1);
        chk("timeout_score", 32'(score), 32'd1);

        // Round 3: matching hit on the fourth lit cycle ends the game
        wait_light();
        k = light_index;
        repeat (3) @(negedge clk);
        chk("race_still_lit", 32'(light_on), 32'd1);
        hit_valid = 1'b1;
        hit_index = k;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("race_score", 32'(score), 32'd2);
        chk("race_misses", 32'(misses), 32'd1);
        chk("race_round_done", 32'(round_done), 32'd1);
        chk("game_over_rise", 32'(game_over), 32'd1);
        chk("done_light_off", 32'(light_on), 32'd0);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) begin
                hit_valid = 1'b1;
                hit_index = k;
            end else begin
                hit_valid = 1'b0;
            end
            held &= game_over && (score == 8'd2) && (misses == 8'd1) && !light_on && !round_done;
        end
        hit_valid = 1'b0;
        chk("done_hold", 32'(held), 32'd1);

        // Game 2: restart clears counters, then wrong-index hits
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_misses", 32'(misses), 32'd0);
        chk("restart_game_over", 32'(game_over), 32'd0);
        wait_light();
        k = light_index;
        hit_valid = 1'b1;
        hit_index = (k == 4'd8) ? 4'd0 : k + 4'd1;
        @(negedge clk);
        chk("wrong_next_score", 32'(score), 32'd0);
        chk("wrong_next_lit", 32'(light_on), 32'd1);
        chk("wrong_next_done", 32'(round_done), 32'd0);
        hit_index = 4'd12;
        @(negedge clk);
        chk("wrong_12_score", 32'(score), 32'd0);
        chk("wrong_12_lit", 32'(light_on), 32'd1);
        hit_index = k;
        @(negedge clk);
        hit_valid = 1'b0;
        chk("right_after_wrong_score", 32'(score), 32'd1);
        chk("right_after_wrong_done", 32'(round_done), 32'd1);
        chk("right_after_wrong_misses", 32'(misses), 32'd0);

        // Mid-round reset during SHOW
        wait_light();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_light", 32'(light_on), 32'd0);
        chk("midrst_score", 32'(score), 32'd0);
        chk("midrst_done", 32'(round_done), 32'd0);
        chk("midrst_index", 32'(light_index), 32'd0);
        @(negedge clk);
        chk("midrst_done_after", 32'(round_done), 32'd0);
        chk("midrst_idle_light", 32'(light_on), 32'd0);

        // Normal run after reset
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!light_on && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_rise", 32'(n), 32'd3);
        wait_round_done();
        chk("post_rst_misses", 32'(misses), 32'd1);
        chk("post_rst_score", 32'(score), 32'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
